// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback request record used by the writeback unit.
package cpu_pkg;

    localparam int unsigned NumRegs      = 32;
    localparam int unsigned DataWidth    = 32;
    localparam int unsigned AddressWidth = 5;

    typedef logic [AddressWidth-1:0] reg_idx_t;
    typedef logic [DataWidth-1:0]    data_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        data_t    data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Valid/ready memory result stream feeding the writeback unit.
interface wb_scoreboard_if;
    import cpu_pkg::*;

    logic     valid;
    logic     ready;
    reg_idx_t rd;
    data_t    data;

    modport master (output valid, rd, data, input ready);
    modport slave  (input valid, rd, data, output ready);
endinterface

// File: rtl/wb_scoreboard_bits.sv
// Pending-write bit vector plus in-flight counter for long-latency destinations.
module scoreboard_bits
    import cpu_pkg::*;
#(
    parameter  int unsigned MaxOutstanding = 4,
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            set_en_i,
    input  reg_idx_t        set_idx_i,
    input  logic            clr_en_i,
    input  reg_idx_t        clr_idx_i,
    input  reg_idx_t        rs1_idx_i,
    input  reg_idx_t        rs2_idx_i,
    output logic            rs1_bit_o,
    output logic            rs2_bit_o,
    output logic            clr_miss_o,
    output logic [CntW-1:0] count_o
);

    logic [NumRegs-1:0] bits_q, bits_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               clr_hit;

    assign clr_hit    = clr_en_i && bits_q[clr_idx_i];
    assign clr_miss_o = clr_en_i && !bits_q[clr_idx_i];
    assign rs1_bit_o  = bits_q[rs1_idx_i];
    assign rs2_bit_o  = bits_q[rs2_idx_i];
    assign count_o    = count_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        bits_d  = bits_q;
        count_d = count_q;
        if (clr_hit) bits_d[clr_idx_i] = 1'b0;
        // Set after clear so a same-register reissue keeps its new reservation.
        if (set_en_i) bits_d[set_idx_i] = 1'b1;
        unique case ({set_en_i, clr_hit})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bits_q  <= '0;
            count_q <= '0;
        end else begin
            bits_q  <= bits_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback unit: ALU/memory arbitration, registered register-file write port and RAW scoreboard.
module wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  iss_valid_i,
    input  reg_idx_t              iss_rd_i,
    output logic                  iss_ready_o,
    input  logic                  alu_valid_i,
    input  reg_idx_t              alu_rd_i,
    input  data_t                 alu_data_i,
    wb_scoreboard_if.slave        mem,
    input  reg_idx_t              rs1_addr_i,
    input  reg_idx_t              rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  wr_en_o,
    output reg_idx_t              rd_addr_o,
    output data_t                 rd_data_o,
    output logic                  err_o
);

    localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic            mem_fire, iss_fire, clr_miss, rs1_bit, rs2_bit;
    logic [CntW-1:0] count;
    wb_req_t         sel;

    // ALU has strict priority; memory is only accepted on ALU-idle cycles.
    assign mem.ready   = !alu_valid_i;
    assign mem_fire    = mem.valid && mem.ready;
    assign iss_ready_o = (count < MaxCnt);
    assign iss_fire    = iss_valid_i && iss_ready_o;

    scoreboard_bits #(.MaxOutstanding(MaxOutstanding)) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_en_i   (iss_fire && (iss_rd_i != '0)),
        .set_idx_i  (iss_rd_i),
        .clr_en_i   (mem_fire && (mem.rd != '0)),
        .clr_idx_i  (mem.rd),
        .rs1_idx_i  (rs1_addr_i),
        .rs2_idx_i  (rs2_addr_i),
        .rs1_bit_o  (rs1_bit),
        .rs2_bit_o  (rs2_bit),
        .clr_miss_o (clr_miss),
        .count_o    (count)
    );

    always_comb begin
        sel = '0;
        if (alu_valid_i) begin
            sel.valid = 1'b1;
            sel.rd    = alu_rd_i;
            sel.data  = alu_data_i;
        end else if (mem_fire) begin
            sel.valid = 1'b1;
            sel.rd    = mem.rd;
            sel.data  = mem.data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_o   <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
            err_o     <= 1'b0;
        end else begin
            wr_en_o <= sel.valid && (sel.rd != '0);
            if (sel.valid) begin
                rd_addr_o <= sel.rd;
                rd_data_o <= sel.data;
            end
            if (clr_miss) err_o <= 1'b1;
        end
    end

    // The register file only sees the write at the next edge, so the pending write counts as busy.
    assign rs1_busy_o = rs1_bit || (wr_en_o && (rd_addr_o == rs1_addr_i) && (rs1_addr_i != '0));
    assign rs2_busy_o = rs2_bit || (wr_en_o && (rd_addr_o == rs2_addr_i) && (rs2_addr_i != '0));

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: reference model plus a queue of expected write-port values.
module tb_wb_scoreboard;
    import cpu_pkg::*;

    localparam int MaxOut = 4;

    logic     clk_i = 1'b0;
    logic     rst_i;
    logic     iss_valid_i;
    reg_idx_t iss_rd_i;
    logic     iss_ready_o;
    logic     alu_valid_i;
    reg_idx_t alu_rd_i;
    data_t    alu_data_i;
    reg_idx_t rs1_addr_i, rs2_addr_i;
    logic     rs1_busy_o, rs2_busy_o;
    logic     wr_en_o;
    reg_idx_t rd_addr_o;
    data_t    rd_data_o;
    logic     err_o;

    wb_scoreboard_if mem_if();

    always #5 clk_i = ~clk_i;

    wb_scoreboard #(.MaxOutstanding(MaxOut)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .iss_ready_o (iss_ready_o),
        .alu_valid_i (alu_valid_i),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .mem         (mem_if),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs1_busy_o  (rs1_busy_o),
        .rs2_busy_o  (rs2_busy_o),
        .wr_en_o     (wr_en_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_o   (rd_data_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic     wr;
        reg_idx_t addr;
        data_t    data;
    } exp_t;

    exp_t         exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [31:0]  m_bits;
    int           m_cnt;
    logic         m_err;
    logic         m_wr;
    reg_idx_t     m_addr;
    data_t        m_data;
    logic         armed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic busy_model(input reg_idx_t rs);
        return m_bits[rs] || (m_wr && (m_addr == rs) && (rs != 0));
    endfunction

    // One clock: check combinational outputs, predict the next state, then compare after the edge.
    task automatic cycle();
        exp_t e;
        logic iss_acc, fire, clr_en, hit;
        #1;
        if (armed) begin
            check("mem_ready", mem_if.ready, !alu_valid_i);
            check("iss_ready", iss_ready_o, m_cnt < MaxOut);
            check("rs1_busy", rs1_busy_o, busy_model(rs1_addr_i));
            check("rs2_busy", rs2_busy_o, busy_model(rs2_addr_i));
        end
        if (rst_i) begin
            m_bits = '0;
            m_cnt  = 0;
            m_err  = 1'b0;
            e.wr   = 1'b0;
            e.addr = '0;
            e.data = '0;
        end else begin
            iss_acc = iss_valid_i && (m_cnt < MaxOut);
            fire    = mem_if.valid && !alu_valid_i;
            clr_en  = fire && (mem_if.rd != 0);
            hit     = clr_en && m_bits[mem_if.rd];
            if (clr_en && !hit) m_err = 1'b1;
            if (hit) begin
                m_bits[mem_if.rd] = 1'b0;
                m_cnt--;
            end
            if (iss_acc && iss_rd_i != 0) begin
                m_bits[iss_rd_i] = 1'b1;
                m_cnt++;
            end
            if (alu_valid_i) begin
                e.wr = (alu_rd_i != 0); e.addr = alu_rd_i; e.data = alu_data_i;
            end else if (fire) begin
                e.wr = (mem_if.rd != 0); e.addr = mem_if.rd; e.data = mem_if.data;
            end else begin
                e.wr = 1'b0; e.addr = m_addr; e.data = m_data;
            end
        end
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        check("wr_en", wr_en_o, e.wr);
        check("rd_addr", rd_addr_o, e.addr);
        check("rd_data", rd_data_o, e.data);
        check("err", err_o, m_err);
        check("count", dut.u_sb.count_o, m_cnt);
        m_wr   = e.wr;
        m_addr = e.addr;
        m_data = e.data;
        armed  = 1'b1;
    endtask

    task automatic idle();
        iss_valid_i  = 1'b0;
        alu_valid_i  = 1'b0;
        mem_if.valid = 1'b0;
    endtask

    task automatic issue(input reg_idx_t rd);
        iss_valid_i = 1'b1;
        iss_rd_i    = rd;
    endtask

    task automatic mem_result(input reg_idx_t rd, input data_t d);
        mem_if.valid = 1'b1;
        mem_if.rd    = rd;
        mem_if.data  = d;
    endtask

    task automatic alu_result(input reg_idx_t rd, input data_t d);
        alu_valid_i = 1'b1;
        alu_rd_i    = rd;
        alu_data_i  = d;
    endtask

    initial begin
        rst_i = 1'b1;
        iss_rd_i = '0; alu_rd_i = '0; alu_data_i = '0;
        mem_if.rd = '0; mem_if.data = '0;
        rs1_addr_i = '0; rs2_addr_i = '0;
        idle();
        cycle();
        rst_i = 1'b0;
        cycle();

        // ALU write and the one-cycle writeback busy window.
        alu_result(5, 32'hDEAD_BEEF); rs1_addr_i = 5; cycle();
        idle(); cycle();
        cycle();

        // Memory result blocked by ALU priority, accepted the next cycle.
        issue(7); rs2_addr_i = 7; cycle();
        idle(); mem_result(7, 32'h0000_1234); alu_result(3, 32'h0000_0333); cycle();
        alu_valid_i = 1'b0; cycle();
        idle(); cycle();
        cycle();

        // Fill to the outstanding limit, then complete while an issue is held off.
        for (int i = 1; i <= 4; i++) begin
            issue(reg_idx_t'(i)); cycle();
        end
        issue(5); cycle();
        issue(9); mem_result(2, 32'h2222); rs1_addr_i = 2; rs2_addr_i = 9; cycle();
        mem_if.valid = 1'b0; cycle();
        idle(); cycle();
        for (int i = 0; i < 4; i++) begin
            reg_idx_t r;
            case (i)
                0: r = 1;
                1: r = 3;
                2: r = 4;
                default: r = 9;
            endcase
            mem_result(r, data_t'(32'hA000 + i)); rs1_addr_i = r; cycle();
        end
        idle(); cycle();

        // Simultaneous issue/completion on the same and on different registers.
        rs1_addr_i = 6; rs2_addr_i = 8;
        issue(6); cycle();
        issue(6); mem_result(6, 32'h6666); cycle();
        issue(8); mem_result(6, 32'h6667); cycle();
        iss_valid_i = 1'b0; mem_result(8, 32'h8888); cycle();
        idle(); cycle();

        // Re-issue to an already busy register.
        rs1_addr_i = 14;
        issue(14); cycle();
        issue(14); cycle();
        idle(); mem_result(14, 32'hEEEE); cycle();
        idle(); cycle();

        // x0 traffic, then a result to an unreserved register.
        mem_result(0, 32'h0BAD); rs1_addr_i = 0; cycle();
        idle(); issue(0); cycle();
        idle(); mem_result(10, 32'h1010); rs2_addr_i = 10; cycle();
        idle(); cycle();
        cycle();

        // Reset with operations outstanding.
        issue(11); cycle();
        issue(12); cycle();
        idle(); rst_i = 1'b1; rs1_addr_i = 11; rs2_addr_i = 12; cycle();
        rst_i = 1'b0; cycle();
        mem_result(11, 32'h1111); cycle();
        idle(); cycle();

        // Random mixed traffic against the model.
        for (int n = 0; n < 60; n++) begin
            iss_valid_i  = ($urandom_range(0, 2) == 0);
            iss_rd_i     = reg_idx_t'($urandom_range(0, 15));
            alu_valid_i  = ($urandom_range(0, 2) == 0);
            alu_rd_i     = reg_idx_t'($urandom_range(0, 15));
            alu_data_i   = data_t'($urandom);
            mem_if.valid = ($urandom_range(0, 1) == 0);
            mem_if.rd    = reg_idx_t'($urandom_range(0, 15));
            mem_if.data  = data_t'($urandom);
            rs1_addr_i   = reg_idx_t'($urandom_range(0, 15));
            rs2_addr_i   = reg_idx_t'($urandom_range(0, 15));
            cycle();
        end
        idle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
